// File: rtl/ej4_pkg.sv
// Shared constants for the GP01 Ej4 recursive filter and its inverse.
package ej4_pkg;

    localparam int unsigned NB_DATA_DEF = 16;
    localparam int unsigned NB_CNT      = 3;
    localparam int unsigned N_TERMS     = 5;
    localparam int unsigned Y1_SHIFT    = 1;
    localparam int unsigned Y2_SHIFT    = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Only the x[n-1] term is added; every other history term is subtracted.
    function automatic logic term_is_sub(input logic [NB_CNT-1:0] cnt);
        return cnt != NB_CNT'(3);
    endfunction

endpackage

// File: rtl/ej4_hist_regs.sv
// History registers of the inverse filter plus the current-sample latch,
// with a term-select mux addressed by the accumulation counter.
module ej4_hist_regs
    import ej4_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF
) (
    input  logic               clock,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_y,
    input  logic               i_commit,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_CNT-1:0]  i_cnt,
    output logic [NB_DATA-1:0] o_term_c
);

    logic [NB_DATA-1:0] r_y_cur;
    logic [NB_DATA-1:0] r_y_m1;
    logic [NB_DATA-1:0] r_y_m2;
    logic [NB_DATA-1:0] r_x_m1;
    logic [NB_DATA-1:0] r_x_m2;
    logic [NB_DATA-1:0] r_x_m3;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y_cur <= '0;
            r_y_m1  <= '0;
            r_y_m2  <= '0;
            r_x_m1  <= '0;
            r_x_m2  <= '0;
            r_x_m3  <= '0;
        end else begin
            if (i_load) begin
                r_y_cur <= i_y;
            end
            // History advances once per sample, when the result is final.
            if (i_commit) begin
                r_y_m2 <= r_y_m1;
                r_y_m1 <= r_y_cur;
                r_x_m3 <= r_x_m2;
                r_x_m2 <= r_x_m1;
                r_x_m1 <= i_result;
            end
        end
    end

    always_comb begin
        o_term_c = '0;
        case (i_cnt)
            NB_CNT'(1): o_term_c = r_y_m1 >> Y1_SHIFT;
            NB_CNT'(2): o_term_c = r_y_m2 >> Y2_SHIFT;
            NB_CNT'(3): o_term_c = r_x_m1;
            NB_CNT'(4): o_term_c = r_x_m2;
            NB_CNT'(5): o_term_c = r_x_m3;
            default:    o_term_c = '0;
        endcase
    end

endmodule

// File: rtl/ej4_inverse_filter.sv
// Inverse of the Ej4 recursive filter: recovers x[n] from y[n] using one
// time-multiplexed adder, five terms per sample, valid/ready on both sides.
module ej4_inverse_filter
    import ej4_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF
) (
    input  logic               clock,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_y,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_x,
    output logic               o_valid,
    input  logic               i_ready
);

    logic [1:0]         r_state;
    logic [NB_DATA-1:0] r_acc;
    logic [NB_CNT-1:0]  r_cnt;
    logic [NB_DATA-1:0] r_x;
    logic               r_valid;
    logic               r_ready;

    logic [1:0]         w_state_next;
    logic [NB_DATA-1:0] w_acc_next;
    logic [NB_CNT-1:0]  w_cnt_next;
    logic [NB_DATA-1:0] w_x_next;
    logic               w_load;
    logic               w_commit;
    logic [NB_DATA-1:0] w_term;
    logic [NB_DATA-1:0] w_sum;

    ej4_hist_regs #(
        .NB_DATA (NB_DATA)
    ) u_hist (
        .clock    (clock),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_y      (i_y),
        .i_commit (w_commit),
        .i_result (w_sum),
        .i_cnt    (r_cnt),
        .o_term_c (w_term)
    );

    assign w_sum = term_is_sub(r_cnt) ? (r_acc - w_term) : (r_acc + w_term);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_x_next     = r_x;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    w_load       = 1'b1;
                    w_acc_next   = i_y;
                    w_cnt_next   = NB_CNT'(1);
                    w_state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                w_acc_next = w_sum;
                if (r_cnt == NB_CNT'(N_TERMS)) begin
                    w_commit     = 1'b1;
                    w_x_next     = w_sum;
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + NB_CNT'(1);
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_x     <= w_x_next;
            r_valid <= (w_state_next == ST_DONE);
            r_ready <= (w_state_next == ST_IDLE);
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_x     = r_x;

endmodule

// File: tb/tb_ej4_inverse_filter.sv
// Scoreboard bench for ej4_inverse_filter: directed vectors, handshake timing,
// stall, reset abort and a forward-filter loopback.
module tb_ej4_inverse_filter;
    import ej4_pkg::*;

    logic        clock = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_y;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] o_x;
    logic        o_valid;
    logic        i_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    longint      cyc      = 0;
    longint      t_accept = 0;
    logic [15:0] exp_q[$];

    logic [15:0] fx1, fx2, fx3, fy1, fy2;

    ej4_inverse_filter #(.NB_DATA(16)) dut (
        .clock   (clock),
        .i_rst_n (i_rst_n),
        .i_y     (i_y),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_x     (o_x),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: compare each consumed output with the oldest expected value.
    always @(negedge clock) begin
        if (i_rst_n && o_valid && i_ready) begin
            if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
            else                   check("x_out", 32'(o_x), 32'(exp_q.pop_front()));
            n_out++;
        end
    end

    // Bit-accurate forward filter.
    task automatic fwd_step(input logic [15:0] x, output logic [15:0] y);
        y   = x - fx1 + fx2 + fx3 + (fy1 >> Y1_SHIFT) + (fy2 >> Y2_SHIFT);
        fx3 = fx2; fx2 = fx1; fx1 = x;
        fy2 = fy1; fy1 = y;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_y     = '0;
        exp_q.delete();
        fx1 = '0; fx2 = '0; fx3 = '0; fy1 = '0; fy2 = '0;
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        i_rst_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_y(input logic [15:0] y);
        int n = 0;
        while (!o_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 100) check("ready_timeout", 32'(o_ready), 32'd1);
        i_y     = y;
        i_valid = 1'b1;
        @(posedge clock); #1;
        t_accept = cyc;
        i_valid  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !o_ready) && n < 300) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish by 2ms");
        $fatal(1);
    end

    initial begin
        longint      ta1;
        int          k;
        logic [15:0] sp[6];
        logic [15:0] xr, yr;

        i_ready = 1'b1;
        do_reset();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid_out", 32'(o_valid), 32'd0);
        check("rst_x", 32'(o_x), 32'd0);

        // Forward impulse response inverts to a unit impulse.
        exp_q.push_back(16'h0001); drive_y(16'h0001);
        exp_q.push_back(16'h0000); drive_y(16'hFFFF);
        exp_q.push_back(16'h0000); drive_y(16'h8000);
        wait_drain();

        // y = 4,4,4 with latency and period checks.
        do_reset();
        exp_q.push_back(16'd4); drive_y(16'd4);
        ta1 = t_accept;
        check("ready_low_e0", 32'(o_ready), 32'd0);
        k = 0;
        while (!o_valid && k < 20) begin
            @(posedge clock); #1; k++;
        end
        check("valid_latency", 32'(k), 32'd5);
        check("ready_low_done", 32'(o_ready), 32'd0);
        @(posedge clock); #1;
        check("ready_after_hs", 32'(o_ready), 32'd1);
        check("valid_after_hs", 32'(o_valid), 32'd0);
        exp_q.push_back(16'd6); drive_y(16'd4);
        check("period", 32'(t_accept - ta1), 32'd7);
        exp_q.push_back(16'd3); drive_y(16'd4);
        wait_drain();

        // Downstream stall with input pulses that must be ignored.
        do_reset();
        i_ready = 1'b0;
        exp_q.push_back(16'd4); drive_y(16'd4);
        k = 0;
        while (!o_valid && k < 20) begin
            @(posedge clock); #1; k++;
        end
        check("stall_latency", 32'(k), 32'd5);
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            i_y     = 16'hABCD;
            @(posedge clock); #1;
            check("stall_x", 32'(o_x), 32'd4);
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_ready", 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        exp_q.push_back(16'd6); drive_y(16'd4);
        exp_q.push_back(16'd3); drive_y(16'd4);
        wait_drain();

        // Reset at cnt=3 drops the sample and clears history.
        drive_y(16'd4);
        repeat (2) @(posedge clock);
        #1;
        do_reset();
        check("abort_ready", 32'(o_ready), 32'd1);
        exp_q.push_back(16'd4); drive_y(16'd4);
        wait_drain();

        // Loopback through the forward model, biased towards wrap values.
        do_reset();
        sp[0] = 16'h7FFF; sp[1] = 16'h8000; sp[2] = 16'hFFFF;
        sp[3] = 16'h0000; sp[4] = 16'h0001; sp[5] = 16'h7FFE;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 2) == 0) xr = sp[$urandom_range(0, 5)];
            else                           xr = 16'($urandom);
            fwd_step(xr, yr);
            exp_q.push_back(xr);
            drive_y(yr);
        end
        wait_drain();

        check("out_count", 32'(n_out), 32'd1010);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
